// File: rtl/vga_timing_gen_if.sv
// Video-side signal bundle of vga_timing_gen: fetch/pixel inputs, sync, data
// enable, prefetch coordinates, boundary strobes and frame status.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned PIX_W = 16
);
  logic             scaleReq;
  logic [PIX_W-1:0] pixelInput;
  logic             hSync;
  logic             fSync;
  logic             de;
  logic [PIX_W-1:0] pixelOutput;
  logic [CNT_W-1:0] xPosAhead;
  logic [CNT_W-1:0] xPos;
  logic [CNT_W-1:0] yPos;
  logic             lineEnd;
  logic             frameEnd;
  logic             scaleAct;
  logic [7:0]       frameCount;

  modport master (
    input  scaleReq, pixelInput,
    output hSync, fSync, de, pixelOutput, xPosAhead, xPos, yPos,
           lineEnd, frameEnd, scaleAct, frameCount
  );

  modport slave (
    output scaleReq, pixelInput,
    input  hSync, fSync, de, pixelOutput, xPosAhead, xPos, yPos,
           lineEnd, frameEnd, scaleAct, frameCount
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with prefetch coordinates,
// frame-latched 1x/2x scaling, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned PREFETCH = 2,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned PIX_W    = 16,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic              clkVGA,
  input logic              rst_n,
  vga_timing_gen_if.master vid
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HA      = H_SYNC + H_BACK;
  localparam int unsigned VA      = V_SYNC + V_BACK;

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYN_END = cnt_t'(H_SYNC);
  localparam cnt_t V_SYN_END = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_BEG = cnt_t'(HA);
  localparam cnt_t H_ACT_END = cnt_t'(HA + H_DISP);
  localparam cnt_t H_REQ_BEG = cnt_t'(HA - PREFETCH);
  localparam cnt_t H_REQ_END = cnt_t'(HA + H_DISP - PREFETCH);
  localparam cnt_t V_ACT_BEG = cnt_t'(VA);
  localparam cnt_t V_ACT_END = cnt_t'(VA + V_DISP);
  localparam cnt_t ONE       = cnt_t'(1);

  cnt_t       h_cnt;
  cnt_t       v_cnt;
  logic       scale_act;
  logic [7:0] frame_count;

  logic line_end;
  logic frame_end;
  logic v_act;
  logic h_act;
  logic h_req;
  cnt_t rx;
  cnt_t rxd;
  cnt_t ry;

  // Halving a raw coordinate gives the source coordinate in 2x mode.
  function automatic cnt_t scale(input cnt_t raw, input logic s2x);
    return s2x ? (raw >> 1) : raw;
  endfunction

  always_ff @(posedge clkVGA or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      scale_act   <= 1'b0;
      frame_count <= '0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + ONE;
      if (line_end)
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
      if (frame_end) begin
        scale_act   <= vid.scaleReq;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  always_comb begin
    line_end  = (h_cnt == H_LAST);
    frame_end = line_end && (v_cnt == V_LAST);
    v_act     = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    h_act     = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    h_req     = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
    // HA-PREFETCH folded into one constant: hCnt-HA+PREFETCH in CNT_W bits.
    rx        = h_cnt - H_REQ_BEG;
    rxd       = h_cnt - H_ACT_BEG;
    ry        = v_cnt - V_ACT_BEG;
  end

  always_comb begin
    vid.hSync       = (h_cnt < H_SYN_END) ? HS_POL : ~HS_POL;
    vid.fSync       = (v_cnt < V_SYN_END) ? VS_POL : ~VS_POL;
    vid.de          = v_act && h_act;
    vid.pixelOutput = (v_act && h_act) ? vid.pixelInput : '0;
    vid.xPosAhead   = (v_act && h_req) ? scale(rx, scale_act) : '1;
    vid.xPos        = (v_act && h_act) ? scale(rxd, scale_act) : '1;
    vid.yPos        = v_act ? scale(ry, scale_act) : '1;
    vid.lineEnd     = line_end;
    vid.frameEnd    = frame_end;
    vid.scaleAct    = scale_act;
    vid.frameCount  = frame_count;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default raster, inverted hsync polarity,
// a medium raster for frame/scale behaviour and a tiny raster for counter wrap.
module tb_vga_timing_gen;

  logic clkVGA = 1'b0;
  always #5 clkVGA = ~clkVGA;

  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;
  logic rst3 = 1'b0;

  vga_timing_gen_if #(.CNT_W(11), .PIX_W(16)) v0 ();
  vga_timing_gen_if #(.CNT_W(11), .PIX_W(16)) v1 ();
  vga_timing_gen_if #(.CNT_W(11), .PIX_W(16)) v2 ();
  vga_timing_gen_if #(.CNT_W(4),  .PIX_W(8))  v3 ();

  vga_timing_gen u0 (.clkVGA(clkVGA), .rst_n(rst0), .vid(v0));

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b0)) u1 (
    .clkVGA(clkVGA), .rst_n(rst1), .vid(v1));

  vga_timing_gen #(
    .H_SYNC(8), .H_BACK(4), .H_DISP(32), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_DISP(20), .V_FRONT(2), .PREFETCH(2)
  ) u2 (.clkVGA(clkVGA), .rst_n(rst2), .vid(v2));

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_DISP(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1), .PREFETCH(0),
    .CNT_W(4), .PIX_W(8)
  ) u3 (.clkVGA(clkVGA), .rst_n(rst3), .vid(v3));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clkVGA);
    #1;
  endtask

  int unsigned h, v, f, sm, fcm, k;
  int unsigned hs_cnt, le_cnt, fe_cnt, fs_cnt, de_cnt;
  int unsigned pix_err, x_err, xa_err, y_err, de_err, fe_err, le_err, fc_err, sa_err;
  int unsigned ex, exa, ey;
  logic de_m, req_m, vact_m;

  initial begin
    v0.scaleReq = 1'b0; v0.pixelInput = '0;
    v1.scaleReq = 1'b0; v1.pixelInput = '0;
    v2.scaleReq = 1'b0; v2.pixelInput = '0;
    v3.scaleReq = 1'b0; v3.pixelInput = '0;
    repeat (3) @(negedge clkVGA);

    // ---------------- default raster: reset state ----------------
    v0.pixelInput = 16'hBEEF;
    #1;
    check("rst_hsync", v0.hSync, 0);
    check("rst_fsync", v0.fSync, 0);
    check("rst_de", v0.de, 0);
    check("rst_pix", v0.pixelOutput, 0);
    check("rst_lineend", v0.lineEnd, 0);
    check("rst_frameend", v0.frameEnd, 0);
    check("rst_xahead", v0.xPosAhead, 11'h7FF);
    check("rst_xpos", v0.xPos, 11'h7FF);
    check("rst_ypos", v0.yPos, 11'h7FF);
    check("rst_scaleact", v0.scaleAct, 0);
    check("rst_framecount", v0.frameCount, 0);

    // ---------------- default raster: first 37 lines ----------------
    rst0 = 1'b1;
    h = 0; v = 0;
    hs_cnt = 0; le_cnt = 0; fe_cnt = 0; fs_cnt = 0; de_cnt = 0;
    pix_err = 0; x_err = 0; xa_err = 0; de_err = 0;
    for (int unsigned n = 0; n < 37 * 800; n++) begin
      vact_m = (v >= 35) && (v < 515);
      de_m   = vact_m && (h >= 144) && (h < 784);
      req_m  = vact_m && (h >= 142) && (h < 782);
      ex  = de_m  ? h - 144 : 32'h7FF;
      exa = req_m ? h - 142 : 32'h7FF;
      if (v == 0 && v0.hSync == 1'b0) hs_cnt++;
      if (v0.lineEnd) le_cnt++;
      if (v0.frameEnd) fe_cnt++;
      if (h == 0 && v0.fSync == 1'b0) fs_cnt++;
      if (v == 35 && v0.de) de_cnt++;
      if (v0.de !== de_m) de_err++;
      if (v0.pixelOutput !== (de_m ? v0.pixelInput : 16'h0)) pix_err++;
      if (v0.xPos !== ex) x_err++;
      if (v0.xPosAhead !== exa) xa_err++;
      if (v == 0 && h == 799) begin
        check("l0_lineend", v0.lineEnd, 1);
        check("l0_frameend", v0.frameEnd, 0);
      end
      if (v == 35) begin
        case (h)
          142: begin
            check("xa_first", v0.xPosAhead, 0);
            check("de_before", v0.de, 0);
          end
          144: begin
            check("x_first", v0.xPos, 0);
            check("de_rise", v0.de, 1);
            check("y_first", v0.yPos, 0);
          end
          781: check("xa_last", v0.xPosAhead, 639);
          782: check("xa_after", v0.xPosAhead, 11'h7FF);
          783: check("x_last", v0.xPos, 639);
          784: begin
            check("x_after", v0.xPos, 11'h7FF);
            check("de_fall", v0.de, 0);
          end
          default: ;
        endcase
      end
      if (v == 34 && h == 300) check("y_before", v0.yPos, 11'h7FF);
      if (v == 36 && h == 200) begin
        check("y_line36", v0.yPos, 1);
        check("x_mid", v0.xPos, 56);
      end
      @(negedge clkVGA);
      v0.pixelInput = 16'($urandom);
      #1;
      h++;
      if (h == 800) begin h = 0; v++; end
    end
    check("hsync_low_clocks", hs_cnt, 96);
    check("lineend_pulses", le_cnt, 37);
    check("frameend_none", fe_cnt, 0);
    check("fsync_low_lines", fs_cnt, 2);
    check("de_clocks_line", de_cnt, 640);
    check("de_track", de_err, 0);
    check("pix_passthru", pix_err, 0);
    check("xpos_track", x_err, 0);
    check("xahead_track", xa_err, 0);

    // ---------------- async reset mid-line ----------------
    v0.pixelInput = 16'h1234;
    repeat (400) tick();
    check("pre_rst_de", v0.de, 1);
    check("pre_rst_fsync", v0.fSync, 1);
    #2;
    rst0 = 1'b0;
    #1;
    check("arst_de", v0.de, 0);
    check("arst_hsync", v0.hSync, 0);
    check("arst_fsync", v0.fSync, 0);
    check("arst_xpos", v0.xPos, 11'h7FF);
    check("arst_ypos", v0.yPos, 11'h7FF);
    check("arst_xahead", v0.xPosAhead, 11'h7FF);
    check("arst_pix", v0.pixelOutput, 0);
    @(negedge clkVGA);
    rst0 = 1'b1;
    k = 0;
    while (!v0.lineEnd && k < 2000) begin
      tick();
      k++;
    end
    check("arst_restart", k, 799);
    rst0 = 1'b0;

    // ---------------- hsync polarity high ----------------
    #1;
    check("pol_rst_hsync", v1.hSync, 1);
    check("pol_rst_fsync", v1.fSync, 0);
    rst1 = 1'b1;
    hs_cnt = 0;
    for (int unsigned n = 0; n < 800; n++) begin
      if (v1.hSync) hs_cnt++;
      if (n == 0)  check("pol_h0", v1.hSync, 1);
      if (n == 95) check("pol_h95", v1.hSync, 1);
      if (n == 96) check("pol_h96", v1.hSync, 0);
      tick();
    end
    check("pol_high_clocks", hs_cnt, 96);
    rst1 = 1'b0;

    // ---------------- medium raster: frames and scale latch ----------------
    // H_TOTAL 48, HA 12; V_TOTAL 27, VA 5; PREFETCH 2
    rst2 = 1'b1;
    h = 0; v = 0; f = 0; sm = 0; fcm = 0;
    fe_cnt = 0; fs_cnt = 0; de_cnt = 0;
    x_err = 0; xa_err = 0; y_err = 0; fe_err = 0; le_err = 0; fc_err = 0; sa_err = 0;
    for (int unsigned n = 0; n < 3 * 1296; n++) begin
      if (f == 0 && v == 10 && h == 0) v2.scaleReq = 1'b1;
      if (f == 1 && v == 10 && h == 0) v2.scaleReq = 1'b0;
      vact_m = (v >= 5) && (v < 25);
      de_m   = vact_m && (h >= 12) && (h < 44);
      req_m  = vact_m && (h >= 10) && (h < 42);
      ex  = de_m   ? (h - 12) >> sm : 32'h7FF;
      exa = req_m  ? (h - 10) >> sm : 32'h7FF;
      ey  = vact_m ? (v - 5) >> sm  : 32'h7FF;
      if (v2.xPos !== ex) x_err++;
      if (v2.xPosAhead !== exa) xa_err++;
      if (v2.yPos !== ey) y_err++;
      if (v2.frameEnd !== (h == 47 && v == 26)) fe_err++;
      if (v2.lineEnd !== (h == 47)) le_err++;
      if (v2.frameCount !== fcm) fc_err++;
      if (v2.scaleAct !== sm) sa_err++;
      if (v2.frameEnd) fe_cnt++;
      if (f == 0 && v2.fSync == 1'b0) fs_cnt++;
      if (f == 0 && v2.de) de_cnt++;
      if (f == 0 && h == 47 && v == 26) begin
        check("m_wrap_lineend", v2.lineEnd, 1);
        check("m_wrap_frameend", v2.frameEnd, 1);
        check("m_scale_hold", v2.scaleAct, 0);
      end
      if (f == 1) begin
        if (h == 0 && v == 0) begin
          check("m_scale_on", v2.scaleAct, 1);
          check("m_fc1", v2.frameCount, 1);
        end
        if (v == 5) begin
          if (h == 10) check("m2x_xa0", v2.xPosAhead, 0);
          if (h == 12) check("m2x_x0a", v2.xPos, 0);
          if (h == 13) check("m2x_x0b", v2.xPos, 0);
          if (h == 14) check("m2x_x1", v2.xPos, 1);
          if (h == 43) check("m2x_xlast", v2.xPos, 15);
        end
        if (v == 6 && h == 20)  check("m2x_y_repeat", v2.yPos, 0);
        if (v == 24 && h == 20) check("m2x_ylast", v2.yPos, 9);
      end
      if (f == 2 && h == 0 && v == 0) begin
        check("m_scale_off", v2.scaleAct, 0);
        check("m_fc2", v2.frameCount, 2);
      end
      if (h == 47 && v == 26) begin
        sm = v2.scaleReq ? 1 : 0;
        fcm++;
      end
      tick();
      h++;
      if (h == 48) begin
        h = 0; v++;
        if (v == 27) begin v = 0; f++; end
      end
    end
    check("m_frameend_pulses", fe_cnt, 3);
    check("m_fsync_clocks", fs_cnt, 96);
    check("m_de_clocks", de_cnt, 640);
    check("m_xpos_track", x_err, 0);
    check("m_xahead_track", xa_err, 0);
    check("m_ypos_track", y_err, 0);
    check("m_frameend_pos", fe_err, 0);
    check("m_lineend_pos", le_err, 0);
    check("m_framecount_track", fc_err, 0);
    check("m_scaleact_track", sa_err, 0);
    rst2 = 1'b0;

    // ---------------- tiny raster: frameCount wrap, PREFETCH 0 ----------------
    // H_TOTAL 8, HA 3; V_TOTAL 6, VA 2; 48 clocks per frame
    v3.pixelInput = 8'hA5;
    rst3 = 1'b1;
    h = 0; v = 0; fcm = 0;
    fc_err = 0; xa_err = 0;
    for (int unsigned n = 0; n < 256 * 48 + 1; n++) begin
      if (v3.frameCount !== 8'(fcm)) fc_err++;
      if (v3.xPosAhead !== v3.xPos) xa_err++;
      if (n == 255 * 48) check("t_fc255", v3.frameCount, 255);
      if (n < 48) begin
        if (h == 7 && v == 5) begin
          check("t_wrap_lineend", v3.lineEnd, 1);
          check("t_wrap_frameend", v3.frameEnd, 1);
        end
        if (h == 3 && v == 2) begin
          check("t_x_first", v3.xPos, 0);
          check("t_de_first", v3.de, 1);
        end
        if (h == 6 && v == 4) begin
          check("t_x_last", v3.xPos, 3);
          check("t_y_last", v3.yPos, 2);
          check("t_pix_on", v3.pixelOutput, 8'hA5);
        end
        if (h == 7 && v == 4) begin
          check("t_pix_off", v3.pixelOutput, 0);
          check("t_x_off", v3.xPos, 4'hF);
        end
      end
      if (h == 7 && v == 5) fcm = (fcm + 1) % 256;
      tick();
      h++;
      if (h == 8) begin
        h = 0; v++;
        if (v == 6) v = 0;
      end
    end
    check("t_fc_wrapped", v3.frameCount, 0);
    check("t_fc_track", fc_err, 0);
    check("t_prefetch0", xa_err, 0);
    rst3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
